// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port arbiter: camera -> mem_* in 1 cycle, overlay via FIFO in >=2 cycles; camera never stalls.
// Overlay backpressure is ovl_ready = !fifo_full (no pop bypass). Optional macro FB_COLORKEY_EN drops KEY_COLOR pixels.

module fb_ovl_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push_vld && !full;
  assign do_pop   = pop_rdy && !empty;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge pclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge pclk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module fb_write_arbiter #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          FB_WORDS   = 76800,
  parameter logic [15:0] KEY_COLOR  = 16'hF81F
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        cam_we,
  input  logic [16:0] cam_wAddr,
  input  logic [15:0] cam_wData,
  input  logic        vsync,
  input  logic        ovl_valid,
  output logic        ovl_ready,
  input  logic [16:0] ovl_addr,
  input  logic [15:0] ovl_data,
  output logic        mem_we,
  output logic [16:0] mem_wAddr,
  output logic [15:0] mem_wData,
  output logic        frame_tick,
  output logic [7:0]  ovl_reject_cnt
);
  typedef struct packed {
    logic [16:0] addr;
    logic [15:0] data;
  } ovl_word_t;

  localparam logic [1:0] ST_SYNC   = 2'd0;
  localparam logic [1:0] ST_BLANK  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

`ifdef FB_COLORKEY_EN
  localparam logic KEY_EN = 1'b1;
`else
  localparam logic KEY_EN = 1'b0;
`endif

  localparam logic [17:0] FB_LIMIT = 18'(FB_WORDS);

  logic [1:0] state;
  logic       vs_d;
  logic       fifo_full;
  logic       fifo_empty;
  logic       accept;
  logic       addr_bad;
  logic       key_hit;
  logic       push;
  logic       pop;
  ovl_word_t  push_word;
  ovl_word_t  head_word;

  assign ovl_ready = !fifo_full;
  assign accept    = ovl_valid && ovl_ready;
  assign addr_bad  = ({1'b0, ovl_addr} >= FB_LIMIT);
  assign key_hit   = KEY_EN && (ovl_data == KEY_COLOR);
  assign push      = accept && !addr_bad && !key_hit;
  // Until the first VSYNC the frame position is unknown, so queued overlay words wait.
  assign pop       = !cam_we && !fifo_empty && (state != ST_SYNC);
  assign push_word = '{addr: ovl_addr, data: ovl_data};

  fb_ovl_fifo #(
    .WIDTH ($bits(ovl_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .pclk     (pclk),
    .reset    (reset),
    .push_vld (push),
    .push_dat (push_word),
    .pop_rdy  (pop),
    .head_dat (head_word),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge pclk) begin
    if (reset) begin
      state      <= ST_SYNC;
      vs_d       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_d       <= vsync;
      frame_tick <= vsync && !vs_d;
      case (state)
        ST_SYNC:   if (vsync)  state <= ST_BLANK;
        ST_BLANK:  if (!vsync) state <= ST_ACTIVE;
        ST_ACTIVE: if (vsync)  state <= ST_BLANK;
        default:   state <= ST_SYNC;
      endcase
    end
  end

  // Camera addresses are passed through unchecked; its writer clamps them.
  always_ff @(posedge pclk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_wAddr <= '0;
      mem_wData <= '0;
    end else if (cam_we) begin
      mem_we    <= 1'b1;
      mem_wAddr <= cam_wAddr;
      mem_wData <= cam_wData;
    end else if (pop) begin
      mem_we    <= 1'b1;
      mem_wAddr <= head_word.addr;
      mem_wData <= head_word.data;
    end else begin
      mem_we    <= 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      ovl_reject_cnt <= '0;
    end else if (accept && addr_bad && (ovl_reject_cnt != 8'hFF)) begin
      ovl_reject_cnt <= ovl_reject_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: queue-based reference model checked every cycle plus hand-computed spot checks.
module tb_fb_write_arbiter;
  localparam int          DEPTH = 4;
  localparam int          FBW   = 76800;
  localparam logic [15:0] KEY   = 16'hF81F;
`ifdef FB_COLORKEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        cam_we = 1'b0;
  logic [16:0] cam_wAddr = '0;
  logic [15:0] cam_wData = '0;
  logic        vsync = 1'b0;
  logic        ovl_valid = 1'b0;
  logic        ovl_ready;
  logic [16:0] ovl_addr = '0;
  logic [15:0] ovl_data = '0;
  logic        mem_we;
  logic [16:0] mem_wAddr;
  logic [15:0] mem_wData;
  logic        frame_tick;
  logic [7:0]  ovl_reject_cnt;

  always #5 pclk = ~pclk;

  fb_write_arbiter #(.FIFO_DEPTH(DEPTH), .FB_WORDS(FBW), .KEY_COLOR(KEY)) dut (
    .pclk           (pclk),
    .reset          (reset),
    .cam_we         (cam_we),
    .cam_wAddr      (cam_wAddr),
    .cam_wData      (cam_wData),
    .vsync          (vsync),
    .ovl_valid      (ovl_valid),
    .ovl_ready      (ovl_ready),
    .ovl_addr       (ovl_addr),
    .ovl_data       (ovl_data),
    .mem_we         (mem_we),
    .mem_wAddr      (mem_wAddr),
    .mem_wData      (mem_wData),
    .frame_tick     (frame_tick),
    .ovl_reject_cnt (ovl_reject_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Reference model: a plain queue of pending words and a "frame seen" flag.
  typedef struct {
    logic [16:0] a;
    logic [15:0] d;
  } word_t;
  word_t       q[$];
  bit          synced;
  bit          prev_vs;
  logic        exp_we;
  logic [16:0] exp_addr;
  logic [15:0] exp_data;
  logic        exp_tick;
  int          exp_rej;

  initial forever begin
    @(posedge pclk);
    if (reset) begin
      q.delete();
      synced = 0; prev_vs = 0;
      exp_we = 0; exp_addr = '0; exp_data = '0; exp_tick = 0; exp_rej = 0;
    end else begin
      word_t w;
      bit    acc;
      acc = ovl_valid && (q.size() < DEPTH);
      if (cam_we) begin
        exp_we = 1; exp_addr = cam_wAddr; exp_data = cam_wData;
      end else if (synced && q.size() > 0) begin
        w = q.pop_front();
        exp_we = 1; exp_addr = w.a; exp_data = w.d;
      end else begin
        exp_we = 0;
      end
      if (acc) begin
        if (int'(ovl_addr) >= FBW) begin
          if (exp_rej < 255) exp_rej++;
        end else if (!(KEY_EN && ovl_data == KEY)) begin
          q.push_back('{a: ovl_addr, d: ovl_data});
        end
      end
      exp_tick = vsync && !prev_vs;
      prev_vs = vsync;
      if (vsync) synced = 1;
    end
  end

  initial forever begin
    @(negedge pclk);
    if (chk_en) begin
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      chk("mem_wAddr", 32'(mem_wAddr), 32'(exp_addr));
      chk("mem_wData", 32'(mem_wData), 32'(exp_data));
      chk("frame_tick", 32'(frame_tick), 32'(exp_tick));
      chk("ovl_reject_cnt", 32'(ovl_reject_cnt), 32'(exp_rej));
      chk("ovl_ready", 32'(ovl_ready), 32'(q.size() < DEPTH));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int  sent;
    int  ovl_w;
    int  cnt;
    bit  saw_nr;
    bit  acc;

    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_wAddr", 32'(mem_wAddr), 0);
    chk("rst_mem_wData", 32'(mem_wData), 0);
    chk("rst_frame_tick", 32'(frame_tick), 0);
    chk("rst_reject", 32'(ovl_reject_cnt), 0);
    chk("rst_ready", 32'(ovl_ready), 1);
    reset = 1'b0;
    tick();

    // Words queued before the first VSYNC wait in the FIFO.
    for (int i = 0; i < 3; i++) begin
      ovl_valid = 1'b1; ovl_addr = 17'(10 + i); ovl_data = 16'hA000 + 16'(i);
      tick();
    end
    ovl_valid = 1'b0;
    repeat (4) begin
      tick();
      chk("sync_hold_we", 32'(mem_we), 0);
    end
    vsync = 1'b1;
    tick();
    chk("vsync_tick", 32'(frame_tick), 1);
    chk("sync_no_pop", 32'(mem_we), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sync_drain_we", 32'(mem_we), 1);
      chk("sync_drain_addr", 32'(mem_wAddr), 32'(10 + i));
    end
    tick();
    chk("sync_drain_done", 32'(mem_we), 0);
    vsync = 1'b0;
    tick();

    // Camera only, alternating strobes.
    for (int i = 0; i < 3; i++) begin
      cam_we = 1'b1; cam_wAddr = 17'(i); cam_wData = 16'h1110 + 16'(i);
      tick();
      chk("cam_we", 32'(mem_we), 1);
      chk("cam_addr", 32'(mem_wAddr), 32'(i));
      chk("cam_data", 32'(mem_wData), 32'h1110 + 32'(i));
      cam_we = 1'b0;
      tick();
      chk("cam_gap_we", 32'(mem_we), 0);
      chk("cam_hold_addr", 32'(mem_wAddr), 32'(i));
    end

    // Four-word overlay burst with idle camera: writes land 2 cycles after acceptance.
    for (int t = 0; t < 6; t++) begin
      ovl_valid = (t < 4); ovl_addr = 17'(100 + t); ovl_data = 16'hB000 + 16'(t);
      chk("burst_ready", 32'(ovl_ready), 1);
      tick();
      if (t >= 1 && t <= 4) begin
        chk("burst_we", 32'(mem_we), 1);
        chk("burst_addr", 32'(mem_wAddr), 32'(99 + t));
      end
      if (t == 5) chk("burst_done", 32'(mem_we), 0);
    end
    ovl_valid = 1'b0;

    // Busy camera plus a 6-word overlay burst: FIFO fills, nothing is lost.
    sent = 0; ovl_w = 0; saw_nr = 0;
    for (int c = 0; c < 40; c++) begin
      cam_we = (c < 8) || ((c % 2 == 0) && (c < 20));
      cam_wAddr = 17'(1000 + c); cam_wData = 16'hC000 + 16'(c);
      ovl_valid = (sent < 6);
      ovl_addr = 17'(200 + sent); ovl_data = 16'hD000 + 16'(sent);
      if (c == 4) chk("full_ready", 32'(ovl_ready), 0);
      if (c == 10) chk("refill_ready", 32'(ovl_ready), 1);
      if (!ovl_ready) saw_nr = 1;
      acc = ovl_valid && ovl_ready;
      tick();
      if (acc) sent++;
      if (mem_we && mem_wAddr >= 17'd200 && mem_wAddr <= 17'd205) ovl_w++;
    end
    cam_we = 1'b0; ovl_valid = 1'b0;
    chk("contend_saw_not_ready", 32'(saw_nr), 1);
    chk("contend_sent", 32'(sent), 6);
    chk("contend_ovl_writes", 32'(ovl_w), 6);

    // Out-of-range overlay addresses are rejected.
    ovl_valid = 1'b1; ovl_addr = 17'd76800; ovl_data = 16'h0001;
    tick();
    chk("rej1_we", 32'(mem_we), 0);
    ovl_addr = 17'd131071;
    tick();
    chk("rej2_we", 32'(mem_we), 0);
    ovl_valid = 1'b0;
    tick();
    chk("rej_none_written", 32'(mem_we), 0);
    chk("rej_count2", 32'(ovl_reject_cnt), 2);

    // Key colour: written unless colour keying is built in.
    ovl_valid = 1'b1; ovl_addr = 17'd50; ovl_data = KEY;
    tick();
    ovl_valid = 1'b0;
    tick();
`ifdef FB_COLORKEY_EN
    chk("key_dropped", 32'(mem_we), 0);
`else
    chk("key_written_we", 32'(mem_we), 1);
    chk("key_written_data", 32'(mem_wData), 32'hF81F);
`endif
    chk("key_no_reject", 32'(ovl_reject_cnt), 2);

    // Last valid address is accepted.
    ovl_valid = 1'b1; ovl_addr = 17'd76799; ovl_data = 16'h7777;
    tick();
    ovl_valid = 1'b0;
    tick();
    chk("edge_we", 32'(mem_we), 1);
    chk("edge_addr", 32'(mem_wAddr), 76799);
    chk("edge_data", 32'(mem_wData), 32'h7777);

    // 300 more rejects saturate the counter.
    for (int i = 0; i < 300; i++) begin
      ovl_valid = 1'b1; ovl_addr = 17'(76800 + (i % 1000)); ovl_data = 16'(i);
      tick();
    end
    ovl_valid = 1'b0;
    tick();
    chk("rej_saturate", 32'(ovl_reject_cnt), 255);
    chk("rej_sat_no_write", 32'(mem_we), 0);

    // Reset with 3 words queued behind the camera flushes them.
    for (int i = 0; i < 3; i++) begin
      cam_we = 1'b1; cam_wAddr = 17'(2000 + i); cam_wData = 16'hE000 + 16'(i);
      ovl_valid = 1'b1; ovl_addr = 17'(300 + i); ovl_data = 16'hF000 + 16'(i);
      tick();
    end
    cam_we = 1'b0; ovl_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("flush_we", 32'(mem_we), 0);
    chk("flush_addr", 32'(mem_wAddr), 0);
    chk("flush_reject", 32'(ovl_reject_cnt), 0);
    chk("flush_ready", 32'(ovl_ready), 1);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      vsync = (i >= 2 && i < 5);
      tick();
      if (mem_we) cnt++;
    end
    vsync = 1'b0;
    chk("flush_nothing_written", 32'(cnt), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
